weight_stream_tx: RTL and testbench
===================================

Name: weight_stream_tx

Overview:
- Transmit side of the weight-load interface: reads the packed LSTM weight image (W_ih then W_hh, 4 gates) word by word from a synchronous weight ROM.
- Pushes each word into the weight_save write port using the wr_fifo_data_valid / wr_fifo_data / fifo_ready handshake.
- Replaces the free-running address counter used today: adds backpressure-safe prefetch, exact word count, done indication and optional continuous reload.

Parameters:
- QZ, 16, weight word width in bits.
- INPUT_SIZE, 96, LSTM input feature count.
- HIDDEN_SIZE, 512, LSTM hidden feature count.
- ADDR_W, 32, ROM address width.
- CONTINUOUS, 0, 1 = restart at address 0 after the last word without a new start.
- Derived localparam TOTAL_WORDS = 4*HIDDEN_SIZE*(INPUT_SIZE+HIDDEN_SIZE). Default is 1245184.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle pulse; begins an image transfer when idle.
- fifo_ready  in  1  sink can accept a word this cycle.
- rom_addr  out  ADDR_W  weight ROM read address.
- rom_rd_en  out  1  ROM read strobe.
- rom_data  in  QZ  ROM read data, valid exactly 1 cycle after rom_rd_en.
- wr_fifo_data_valid  out  1  wr_fifo_data holds a valid word.
- wr_fifo_data  out  QZ  weight word to sink.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse after the last word of an image is accepted.
- words_sent  out  ADDR_W  count of words accepted in the current image.

Behaviour:
- Reset (rst_n=0 at posedge clk): state IDLE. All outputs 0: rom_addr, rom_rd_en, wr_fifo_data_valid, wr_fifo_data, busy, done, words_sent. Prefetch buffer is emptied. Reset mid-transfer discards in-flight reads; no further valid is asserted.
- Transfer rule: a word is transferred on a cycle where wr_fifo_data_valid=1 and fifo_ready=1.
- While wr_fifo_data_valid=1 and fifo_ready=0, wr_fifo_data must hold stable.
- Data path: output register plus one skid register, giving 2 entries. occ counts buffered entries plus the read in flight, range 0..2.
- Read issue: rom_rd_en=1 when state=STREAM, read pointer < TOTAL_WORDS, and (occ - transfer_this_cycle) < 2. The rom_addr value presented with rom_rd_en is the read pointer, which then increments by 1.
- Returning rom_data goes to the output register if it is empty or being drained this cycle, otherwise to the skid register. Words leave strictly in ascending address order.
- Throughput: 1 word/cycle sustained when fifo_ready is held at 1.
- Start latency: first wr_fifo_data_valid occurs 3 cycles after the start cycle (start, then rd issue, then data registered).

State machine:
- IDLE: busy=0. start moves to STREAM; read pointer and words_sent are cleared.
- STREAM: busy=1. When read pointer = TOTAL_WORDS, go to DRAIN.
- DRAIN: no reads issued. When the final transfer occurs (words_sent becomes TOTAL_WORDS), done=1 on the next cycle.
  - If CONTINUOUS=0, go to IDLE.
  - If CONTINUOUS=1, clear pointers and go to STREAM. busy stays 1 with no idle gap beyond refill latency.
- start while busy is ignored. start in the same cycle as the done pulse is honoured only in IDLE, i.e. from the next cycle.

Counters and boundaries:
- words_sent increments by 1 per transfer and saturates at TOTAL_WORDS until the next start.
- fifo_ready may toggle every cycle; no word may be duplicated or dropped.
- fifo_ready=0 during the read-in-flight cycle: the returning word lands in the skid register and rom_rd_en stays 0 until occ < 2.
- TOTAL_WORDS must be < 2^ADDR_W; this is checked by an elaboration-time assertion.

Test Plan:
- INPUT_SIZE=2, HIDDEN_SIZE=2 (TOTAL_WORDS=32), ROM data = address+0x100, fifo_ready=1, start pulse → 32 transfers on consecutive cycles, values 0x100..0x11F. First valid 3 cycles after start. done pulses once 1 cycle after the 0x11F transfer. busy then falls, words_sent=32.
- Same config, fifo_ready random at 50% → received sequence is exactly 0x100..0x11F with no gaps or duplicates. wr_fifo_data is stable whenever valid=1 and ready=0. Issued ROM reads are never more than 2 ahead of accepted transfers.
- fifo_ready=0 for 20 cycles immediately after start → at most 2 reads issued (addr 0,1). valid=1 with data 0x100 is held. Release gives 0x100, 0x101, 0x102… with no loss.
- start pulsed again at word 10 → ignored; stream continues to 32; single done pulse.
- rst_n=0 for 1 cycle at word 15 → next cycle all outputs 0 and state IDLE. A new start restarts from 0x100.
- CONTINUOUS=1, fifo_ready=1 → after 0x11F, done pulses and the stream resumes with 0x100. busy stays 1. Two done pulses over 64+ transfers.

Source files
------------

// File: rtl/weight_stream_tx.sv
// -----------------------------------------------------------------------------
// weight_stream_tx
//   Transmit side of the LSTM weight-load interface. Walks the packed weight
//   image (W_ih then W_hh, four gates) out of a synchronous weight ROM and
//   pushes each word into the weight_save write port through a valid/ready
//   handshake. A two-entry buffer (output register + skid register) absorbs the
//   one-cycle ROM latency so backpressure never drops or duplicates a word and
//   a ready-held sink sees one word per cycle.
//
// Ports
//   clk                 clock
//   rst_n               synchronous active-low reset
//   start               one-cycle pulse, begins an image transfer when idle
//   fifo_ready          sink accepts a word this cycle
//   rom_addr            ROM read address (current read pointer)
//   rom_rd_en           ROM read strobe
//   rom_data            ROM read data, valid the cycle after rom_rd_en
//   wr_fifo_data_valid  wr_fifo_data holds a valid word
//   wr_fifo_data        weight word to the sink
//   busy                transfer in progress
//   done                one-cycle pulse after the last word is accepted
//   words_sent          words accepted in the current image
// -----------------------------------------------------------------------------
module weight_stream_tx #(
  parameter int QZ          = 16,
  parameter int INPUT_SIZE  = 96,
  parameter int HIDDEN_SIZE = 512,
  parameter int ADDR_W      = 32,
  parameter bit CONTINUOUS  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              fifo_ready,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd_en,
  input  logic [QZ-1:0]     rom_data,
  output logic              wr_fifo_data_valid,
  output logic [QZ-1:0]     wr_fifo_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] words_sent
);

  localparam longint unsigned TOTAL_WORDS =
    64'd4 * 64'(HIDDEN_SIZE) * 64'(INPUT_SIZE + HIDDEN_SIZE);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(TOTAL_WORDS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TOTAL_WORDS - 64'd1);

  // The word counter and read pointer must be able to hold TOTAL_WORDS itself.
  if (ADDR_W >= 64 || TOTAL_WORDS >= (64'd1 << ADDR_W)) begin : g_size_check
    $error("weight_stream_tx: TOTAL_WORDS does not fit in ADDR_W bits");
  end

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   rd_ptr;
  logic                rd_inflight;   // a ROM read was issued last cycle
  logic                out_valid;
  logic [QZ-1:0]       out_data;
  logic                skid_valid;
  logic [QZ-1:0]       skid_data;
  logic                busy_q;
  logic                done_q;
  logic [ADDR_W-1:0]   words_q;

  logic                xfer;
  logic                final_xfer;
  logic [1:0]          occ;
  logic [1:0]          occ_net;
  logic                rd_issue;

  assign xfer       = out_valid & fifo_ready;
  assign final_xfer = xfer && (words_q == LAST_IDX);

  // NOTE: every signal written in always_comb gets a value on every path
  // (here unconditionally), otherwise synthesis infers a latch.
  always_comb begin
    // Buffered words plus the read still in flight; never exceeds 2.
    occ      = 2'(out_valid) + 2'(skid_valid) + 2'(rd_inflight);
    // Space freed by a word leaving this cycle may be refilled immediately,
    // which is what sustains one word per cycle.
    occ_net  = occ - 2'(xfer);
    rd_issue = (state == STREAM) && (rd_ptr < LAST_PTR) && (occ_net < 2'd2);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset too, because the block must present
      // all-zero outputs after reset; they are only two words wide.
      state       <= IDLE;
      rd_ptr      <= '0;
      rd_inflight <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      skid_valid  <= 1'b0;
      skid_data   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      words_q     <= '0;
    end else begin
      done_q      <= final_xfer;
      rd_inflight <= rd_issue;
      if (rd_issue) rd_ptr <= rd_ptr + ADDR_W'(1);

      // Output register refills from the skid first (older word), then from
      // the returning ROM data. Skid and in-flight read never coexist while
      // the output is full, so ordering is preserved.
      if (!out_valid || xfer) begin
        if (skid_valid) begin
          out_data   <= skid_data;
          out_valid  <= 1'b1;
          skid_valid <= 1'b0;
        end else if (rd_inflight) begin
          out_data  <= rom_data;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (rd_inflight) begin
        skid_data  <= rom_data;
        skid_valid <= 1'b1;
      end

      if (xfer && (words_q != LAST_PTR)) words_q <= words_q + ADDR_W'(1);

      case (state)
        IDLE: begin
          if (start) begin
            state   <= STREAM;
            busy_q  <= 1'b1;
            rd_ptr  <= '0;
            words_q <= '0;
          end
        end
        STREAM: begin
          if (rd_ptr == LAST_PTR) state <= DRAIN;
        end
        DRAIN: begin
          // Leave only after the done pulse, so a start that coincides with
          // done is still ignored.
          if (done_q) begin
            if (CONTINUOUS) begin
              state   <= STREAM;
              rd_ptr  <= '0;
              words_q <= '0;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rom_addr           = rd_ptr;
  assign rom_rd_en          = rd_issue;
  assign wr_fifo_data_valid = out_valid;
  assign wr_fifo_data       = out_data;
  assign busy               = busy_q;
  assign done               = done_q;
  assign words_sent         = words_q;

endmodule

// File: tb/tb_weight_stream_tx.sv
// -----------------------------------------------------------------------------
// tb_weight_stream_tx
//   Bench for weight_stream_tx with INPUT_SIZE=2, HIDDEN_SIZE=2 (32 words).
//   Two instances share the inputs: CONTINUOUS=0 and CONTINUOUS=1; 'sel'
//   chooses which one is observed. Each has its own ROM model returning
//   address+0x100 one cycle after a read (0xDEAD when no read was issued).
// -----------------------------------------------------------------------------
module tb_weight_stream_tx;

  localparam int QZ    = 16;
  localparam int AW    = 32;
  localparam int TOTAL = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic fifo_ready = 1'b0;
  logic sel = 1'b0;

  logic [AW-1:0] addr0, addr1, words0, words1;
  logic          rd0, rd1, v0, v1, busy0, busy1, done0, done1;
  logic [QZ-1:0] rom0 = 16'hDEAD;
  logic [QZ-1:0] rom1 = 16'hDEAD;
  logic [QZ-1:0] d0, d1;

  always #5 clk = ~clk;

  weight_stream_tx #(.QZ(QZ), .INPUT_SIZE(2), .HIDDEN_SIZE(2), .ADDR_W(AW),
                     .CONTINUOUS(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fifo_ready(fifo_ready),
    .rom_addr(addr0), .rom_rd_en(rd0), .rom_data(rom0),
    .wr_fifo_data_valid(v0), .wr_fifo_data(d0),
    .busy(busy0), .done(done0), .words_sent(words0));

  weight_stream_tx #(.QZ(QZ), .INPUT_SIZE(2), .HIDDEN_SIZE(2), .ADDR_W(AW),
                     .CONTINUOUS(1'b1)) dut_cont (
    .clk(clk), .rst_n(rst_n), .start(start), .fifo_ready(fifo_ready),
    .rom_addr(addr1), .rom_rd_en(rd1), .rom_data(rom1),
    .wr_fifo_data_valid(v1), .wr_fifo_data(d1),
    .busy(busy1), .done(done1), .words_sent(words1));

  always @(posedge clk) begin
    rom0 <= rd0 ? (16'h100 + addr0[15:0]) : 16'hDEAD;
    rom1 <= rd1 ? (16'h100 + addr1[15:0]) : 16'hDEAD;
  end

  logic          o_valid, o_busy, o_done, o_rd;
  logic [QZ-1:0] o_data;
  logic [AW-1:0] o_addr, o_words;

  always_comb begin
    o_valid = sel ? v1     : v0;
    o_data  = sel ? d1     : d0;
    o_busy  = sel ? busy1  : busy0;
    o_done  = sel ? done1  : done0;
    o_rd    = sel ? rd1    : rd0;
    o_addr  = sel ? addr1  : addr0;
    o_words = sel ? words1 : words0;
  end

  int tests = 0;
  int fails = 0;

  // Scoreboard for streaming runs.
  int            exp_idx, issued, accepted, done_count;
  bit            prev_hold;
  logic [QZ-1:0] prev_data;

  typedef struct {
    logic          start;
    logic          ready;
    logic          valid;
    logic [QZ-1:0] data;
    logic          busy;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic [AW-1:0] words;
  } vec_t;

  vec_t vecs[25];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    fifo_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    #1;
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_data"},  o_data,  0);
    check({tag, "_busy"},  o_busy,  0);
    check({tag, "_done"},  o_done,  0);
    check({tag, "_rd_en"}, o_rd,    0);
    check({tag, "_addr"},  o_addr,  0);
    check({tag, "_words"}, o_words, 0);
  endtask

  task automatic observe(input int c, input bit first);
    if (c >= 1 || !first) check("busy", o_busy, 1);
    if (prev_hold) begin
      check("hold_valid", o_valid, 1);
      check("hold_data", o_data, prev_data);
    end
    if (sel == 1'b0) check("words_sent", o_words, accepted);
    if (o_rd) begin
      check("rd_addr", o_addr, issued % TOTAL);
      issued++;
    end
    if (o_valid && fifo_ready) begin
      check("xfer_data", o_data, 16'h100 + (exp_idx % TOTAL));
      exp_idx++;
      accepted++;
    end
    check("rd_ahead", (issued - accepted) <= 2, 1);
    if (o_done) done_count++;
    prev_hold = o_valid && !fifo_ready;
    prev_data = o_data;
  endtask

  // Runs cycles from a negedge until want_done done pulses or stop_at words.
  task automatic run_stream(input bit first, input bit rnd, input int restart_at,
                            input int want_done, input int stop_at, input int budget);
    bit finished;
    bit pulsed;
    finished = 1'b0;
    pulsed = 1'b0;
    if (first) begin
      exp_idx = 0; issued = 0; accepted = 0; done_count = 0;
      prev_hold = 1'b0; prev_data = '0;
    end
    for (int c = 0; c < budget; c++) begin
      start = (first && c == 0) || (!pulsed && accepted == restart_at);
      if (accepted == restart_at) pulsed = 1'b1;
      fifo_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      observe(c, first);
      @(negedge clk);
      if (done_count == want_done || accepted == stop_at) begin
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check("stream_budget", finished, 1);
  endtask

  task automatic post_done(input string tag);
    start = 1'b0;
    fifo_ready = 1'b1;
    #1;
    check({tag, "_xfers"},     accepted, TOTAL);
    check({tag, "_done_once"}, done_count, 1);
    check({tag, "_busy_fall"}, o_busy, 0);
    check({tag, "_done_low"},  o_done, 0);
    check({tag, "_words"},     o_words, TOTAL);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Backpressure-at-start vectors: fifo_ready low for cycles 1..20.
    for (int c = 0; c < 25; c++) begin
      vecs[c].start = (c == 0);
      vecs[c].ready = (c >= 21);
      vecs[c].valid = (c >= 3);
      vecs[c].data  = (c <= 21) ? 16'h100 : 16'(16'h100 + c - 21);
      vecs[c].busy  = (c >= 1);
      vecs[c].rd_en = (c == 1) || (c == 2) || (c >= 21);
      vecs[c].addr  = (c == 1) ? 0 : (c == 2) ? 1 : AW'(c - 19);
      vecs[c].words = (c <= 21) ? 0 : AW'(c - 21);
    end

    @(negedge clk);
    do_reset();
    check_zero("reset");
    @(negedge clk);

    // Full-rate image: first valid 3 cycles after start, done one cycle after
    // the last transfer, a start in the done cycle is ignored.
    for (int c = 0; c < 38; c++) begin
      start = (c == 0) || (c == 35);
      fifo_ready = 1'b1;
      #1;
      check("t1_valid", o_valid, (c >= 3 && c <= 34));
      if (c >= 3 && c <= 34) check("t1_data", o_data, 16'h100 + c - 3);
      check("t1_done", o_done, (c == 35));
      check("t1_busy", o_busy, (c >= 1 && c <= 35));
      @(negedge clk);
    end
    start = 1'b0;
    #1;
    check("t1_words", o_words, TOTAL);
    @(negedge clk);

    // Stall right after start.
    do_reset();
    for (int i = 0; i < 25; i++) begin
      start = vecs[i].start;
      fifo_ready = vecs[i].ready;
      #1;
      check("t3_valid", o_valid, vecs[i].valid);
      if (vecs[i].valid) check("t3_data", o_data, vecs[i].data);
      check("t3_busy",  o_busy, vecs[i].busy);
      check("t3_rd_en", o_rd,   vecs[i].rd_en);
      if (vecs[i].rd_en) check("t3_addr", o_addr, vecs[i].addr);
      check("t3_words", o_words, vecs[i].words);
      check("t3_done",  o_done, 0);
      @(negedge clk);
    end
    exp_idx = 4; issued = 6; accepted = 4; done_count = 0;
    prev_hold = 1'b0; prev_data = '0;
    run_stream(1'b0, 1'b0, -1, 1, -1, 200);
    post_done("t3");

    // Random backpressure.
    do_reset();
    run_stream(1'b1, 1'b1, -1, 1, -1, 500);
    post_done("t2");

    // Start while busy is ignored.
    do_reset();
    run_stream(1'b1, 1'b0, 10, 1, -1, 200);
    post_done("t4");

    // Reset in the middle of a transfer, then a clean restart.
    do_reset();
    run_stream(1'b1, 1'b1, -1, 1, 15, 500);
    rst_n = 1'b0;
    fifo_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_zero("t5_idle");
      @(negedge clk);
    end
    run_stream(1'b1, 1'b1, -1, 1, -1, 500);
    post_done("t5");

    // Continuous reload: two images back to back, busy never drops.
    sel = 1'b1;
    do_reset();
    check_zero("t6_reset");
    @(negedge clk);
    run_stream(1'b1, 1'b0, -1, 2, -1, 300);
    check("t6_xfers", accepted, 2 * TOTAL);
    check("t6_dones", done_count, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
